// File: rtl/alarm_ctrl_pkg.sv
// Shared constants, state encoding and width helper for the alarm controller.
// Pure definitions: no logic, no latency, no flow control.
package alarm_ctrl_pkg;

    localparam logic [3:0] SEP_NIBBLE = 4'ha;
    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MIN_MAX    = 8'h59;
    localparam logic [7:0] HOUR_RST   = 8'h07;
    localparam logic [7:0] MIN_RST    = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_wrap_inc.sv
// Two-digit BCD increment that wraps MAX_VAL back to 00 (no carry out).
// Purely combinational; zero latency, no flow control.
module bcd_wrap_inc #(
    parameter logic [7:0] MAX_VAL = 8'h59
) (
    input  logic [7:0] val,
    output logic [7:0] nxt
);

    always_comb begin
        nxt = val;
        if (val >= MAX_VAL) begin
            nxt = 8'h00;
        end else if (val[3:0] >= 4'd9) begin
            nxt = {val[7:4] + 4'd1, 4'd0};
        end else begin
            nxt = {val[7:4], val[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: BCD alarm setting, time match, IDLE/RING/SNOOZE FSM and buzzer.
// Trigger reaches ringing two edges after cnt_24 matches; key pulses are never back-pressured.
module alarm_ctrl #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int TONE_DIV   = 25_000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        set_hour_pre,
    input  logic        set_min_pre,
    input  logic        alarm_on_pre,
    input  logic        stop_pre,
    input  logic        snooze_pre,
    input  logic        mode_alarm,
    input  logic [31:0] cnt_24,
    output logic        alarm_en,
    output logic        ringing,
    output logic        beep,
    output logic [31:0] data_alarm
);

    import alarm_ctrl_pkg::*;

    localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int PW      = cnt_width(CLK_FREQ);
    localparam int SW      = cnt_width(SEC_MAX + 1);
    localparam int TW      = cnt_width(TONE_DIV);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_FREQ / 2 - 1);
    localparam logic [SW-1:0] RING_LIM   = SW'(RING_SEC);
    localparam logic [SW-1:0] SNOOZE_LIM = SW'(SNOOZE_SEC);
    localparam logic [TW-1:0] TONE_LAST  = TW'(TONE_DIV - 1);

    logic [7:0]    alarm_hour;
    logic [7:0]    alarm_min;
    logic [7:0]    hour_nxt;
    logic [7:0]    min_nxt;
    logic          match_now;
    logic          match_q;
    logic          match_d;
    logic          trigger;
    state_t        state;
    state_t        next_state;
    logic          state_change;
    logic [PW-1:0] presc;
    logic          sec_tick;
    logic [SW-1:0] sec_cnt;
    logic [SW-1:0] sec_inc;
    logic          ring_timeout;
    logic          snooze_timeout;
    logic [TW-1:0] tone_cnt;
    logic          tone;
    logic          cadence;
    logic          unused_sep;

    bcd_wrap_inc #(.MAX_VAL(HOUR_MAX)) u_hour_inc (
        .val (alarm_hour),
        .nxt (hour_nxt)
    );

    bcd_wrap_inc #(.MAX_VAL(MIN_MAX)) u_min_inc (
        .val (alarm_min),
        .nxt (min_nxt)
    );

    // Setting keys act independently of each other and of the FSM.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hour <= HOUR_RST;
            alarm_min  <= MIN_RST;
            alarm_en   <= 1'b0;
        end else if (mode_alarm) begin
            if (set_hour_pre) alarm_hour <= hour_nxt;
            if (set_min_pre)  alarm_min  <= min_nxt;
            if (alarm_on_pre) alarm_en   <= ~alarm_en;
        end
    end

    // Separator nibbles of the live time carry no information.
    assign unused_sep = ^{cnt_24[23:20], cnt_24[11:8]};

    assign match_now = alarm_en
                     & (cnt_24[31:24] == alarm_hour)
                     & (cnt_24[19:12] == alarm_min)
                     & (cnt_24[7:0]   == 8'h00);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
            match_d <= 1'b0;
        end else begin
            match_q <= match_now;
            match_d <= match_q;
        end
    end

    // A held match only fires once; a new rising edge is needed to re-arm.
    assign trigger = match_q & ~match_d;

    assign sec_tick       = (presc == PRESC_LAST);
    assign sec_inc        = sec_cnt + SW'(1);
    assign ring_timeout   = sec_tick && (sec_inc == RING_LIM);
    assign snooze_timeout = sec_tick && (sec_inc == SNOOZE_LIM);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (trigger) next_state = ST_RING;
            end
            ST_RING: begin
                if (stop_pre || !alarm_en || ring_timeout) next_state = ST_IDLE;
                else if (snooze_pre)                       next_state = ST_SNOOZE;
            end
            ST_SNOOZE: begin
                if (stop_pre || !alarm_en) next_state = ST_IDLE;
                else if (snooze_timeout)   next_state = ST_RING;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign state_change = (next_state != state);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ringing <= 1'b0;
        end else begin
            state   <= next_state;
            ringing <= (next_state == ST_RING);
        end
    end

    // Every state entry restarts a full second, so the cadence phase restarts too.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            sec_cnt <= '0;
            cadence <= 1'b0;
        end else if (state_change) begin
            presc   <= '0;
            sec_cnt <= '0;
            cadence <= 1'b0;
        end else begin
            presc <= sec_tick ? '0 : presc + PW'(1);
            if (sec_tick && state != ST_IDLE) sec_cnt <= sec_inc;
            if (sec_tick || presc == PRESC_HALF) cadence <= ~cadence;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone     <= ~tone;
        end else begin
            tone_cnt <= tone_cnt + TW'(1);
        end
    end

    // Built only from reset-cleared registers, so reset silences it without a clock.
    assign beep = ringing & tone & cadence;

    assign data_alarm = {alarm_hour, SEP_NIBBLE, alarm_min, SEP_NIBBLE, 8'h00};

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: table-driven key vectors, directed ring/snooze/reset sequences,
// and randomized traffic against a cycle-count reference model.
module tb_alarm_ctrl;

    localparam int CF = 10;
    localparam int RS = 3;
    localparam int SS = 2;
    localparam int TD = 2;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        set_hour_pre = 1'b0;
    logic        set_min_pre = 1'b0;
    logic        alarm_on_pre = 1'b0;
    logic        stop_pre = 1'b0;
    logic        snooze_pre = 1'b0;
    logic        mode_alarm = 1'b0;
    logic [31:0] cnt_24 = 32'h06a59a59;
    logic        alarm_en;
    logic        ringing;
    logic        beep;
    logic [31:0] data_alarm;

    alarm_ctrl #(
        .CLK_FREQ   (CF),
        .RING_SEC   (RS),
        .SNOOZE_SEC (SS),
        .TONE_DIV   (TD)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .set_hour_pre (set_hour_pre),
        .set_min_pre  (set_min_pre),
        .alarm_on_pre (alarm_on_pre),
        .stop_pre     (stop_pre),
        .snooze_pre   (snooze_pre),
        .mode_alarm   (mode_alarm),
        .cnt_24       (cnt_24),
        .alarm_en     (alarm_en),
        .ringing      (ringing),
        .beep         (beep),
        .data_alarm   (data_alarm)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int beep_seen = 0;
    logic [31:0] cur_cnt = 32'h06a59a59;

    // Reference model: alarm time as integers, phase as 0 idle / 1 ring / 2 snooze,
    // and elapsed clock cycles since the phase began.
    int m_h, m_m, m_st, m_el;
    bit m_en, m1, m2;

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h = 7; m_m = 0; m_en = 0; m_st = 0; m_el = 0; m1 = 0; m2 = 0;
    endtask

    task automatic model_step();
        int  nst;
        bit  mnow, trig;
        mnow = m_en && cnt_24[31:24] == bcd(m_h) && cnt_24[19:12] == bcd(m_m)
               && cnt_24[7:0] == 8'h00;
        trig = m1 && !m2;
        nst = m_st;
        if (m_st == 0) begin
            if (trig) nst = 1;
        end else if (m_st == 1) begin
            if (stop_pre || !m_en || m_el == RS * CF - 1) nst = 0;
            else if (snooze_pre) nst = 2;
        end else begin
            if (stop_pre || !m_en) nst = 0;
            else if (m_el == SS * CF - 1) nst = 1;
        end
        m_el = (nst != m_st) ? 0 : m_el + 1;
        m_st = nst;
        m2 = m1;
        m1 = mnow;
        if (mode_alarm) begin
            if (set_hour_pre) m_h = (m_h + 1) % 24;
            if (set_min_pre)  m_m = (m_m + 1) % 60;
            if (alarm_on_pre) m_en = !m_en;
        end
    endtask

    // One clock: drive inputs, let the edge pass, compare against the model.
    task automatic tick(input logic sh, input logic sm, input logic ao,
                        input logic st, input logic sn, input logic md);
        set_hour_pre = sh; set_min_pre = sm; alarm_on_pre = ao;
        stop_pre = st; snooze_pre = sn; mode_alarm = md; cnt_24 = cur_cnt;
        @(posedge sys_clk);
        model_step();
        #1;
        chk("ringing", 32'(ringing), 32'(m_st == 1));
        chk("alarm_en", 32'(alarm_en), 32'(m_en));
        chk("data_alarm", data_alarm, {bcd(m_h), 4'ha, bcd(m_m), 4'ha, 8'h00});
        if (!ringing) chk("beep_quiet", 32'(beep), 32'h0);
        if (beep) beep_seen++;
        set_hour_pre = 0; set_min_pre = 0; alarm_on_pre = 0;
        stop_pre = 0; snooze_pre = 0; mode_alarm = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
    endtask

    // Move the live time away and back onto 07:00:00, then wait for RING.
    task automatic retrigger();
        int k;
        cur_cnt = 32'h06a59a59;
        tick(0, 0, 0, 0, 0, 0);
        cur_cnt = 32'h07a00a00;
        k = 0;
        while (!ringing && k < 5) begin
            tick(0, 0, 0, 0, 0, 0);
            k++;
        end
        chk("retrigger_ring", 32'(ringing), 32'h1);
    endtask

    typedef struct {
        logic        sh, sm, ao, md;
        logic [31:0] exp_data;
        logic        exp_en;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{1, 0, 0, 1, 32'h08a00a00, 0};
        tbl[1] = '{0, 1, 0, 1, 32'h08a01a00, 0};
        tbl[2] = '{1, 1, 1, 0, 32'h08a01a00, 0};
        tbl[3] = '{0, 0, 1, 1, 32'h08a01a00, 1};
        tbl[4] = '{1, 1, 1, 1, 32'h09a02a00, 0};
        tbl[5] = '{0, 0, 1, 0, 32'h09a02a00, 0};
        tbl[6] = '{0, 0, 1, 1, 32'h09a02a00, 1};

        model_reset();
        #12 rst_n = 1'b1;
        chk("rst_data_alarm", data_alarm, 32'h07a00a00);
        chk("rst_alarm_en", 32'(alarm_en), 32'h0);
        chk("rst_beep", 32'(beep), 32'h0);
        chk("rst_ringing", 32'(ringing), 32'h0);

        // Full hour and minute wrap, including the BCD digit carry.
        for (int i = 0; i < 24; i++) begin
            tick(1, 0, 0, 0, 0, 1);
            if (i == 2)  chk("hour_digit_carry", 32'(data_alarm[31:24]), 32'h10);
            if (i == 16) chk("hour_wrap_23_00", 32'(data_alarm[31:24]), 32'h00);
        end
        chk("hour_full_cycle", 32'(data_alarm[31:24]), 32'h07);
        for (int i = 0; i < 60; i++) begin
            tick(0, 1, 0, 0, 0, 1);
            if (i == 9) chk("min_digit_carry", 32'(data_alarm[19:12]), 32'h10);
        end
        chk("min_full_cycle", data_alarm, 32'h07a00a00);

        for (int i = 0; i < 7; i++) begin
            tick(tbl[i].sh, tbl[i].sm, tbl[i].ao, 0, 0, tbl[i].md);
            chk($sformatf("tbl%0d_data", i), data_alarm, tbl[i].exp_data);
            chk($sformatf("tbl%0d_en", i), 32'(alarm_en), 32'(tbl[i].exp_en));
        end

        rst_n = 1'b0;
        #3;
        model_reset();
        chk("rst2_data_alarm", data_alarm, 32'h07a00a00);
        chk("rst2_alarm_en", 32'(alarm_en), 32'h0);
        #2 rst_n = 1'b1;

        // Trigger latency and no retrigger on a held match.
        tick(0, 0, 1, 0, 0, 1);
        cur_cnt = 32'h07a00a00;
        tick(0, 0, 0, 0, 0, 0);
        chk("ring_edge1", 32'(ringing), 32'h0);
        tick(0, 0, 0, 0, 0, 0);
        chk("ring_edge2", 32'(ringing), 32'h1);
        idle(5);
        tick(0, 0, 0, 1, 0, 0);
        chk("stop_idle", 32'(ringing), 32'h0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            if (ringing) n++;
        end
        chk("no_retrigger", 32'(n), 32'h0);

        // Unattended ring length.
        retrigger();
        n = 1;
        for (int i = 0; i < 100 && ringing; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            if (ringing) n++;
        end
        chk("ring_len_cycles", 32'(n), 32'(RS * CF));
        chk("beep_at_timeout", 32'(beep), 32'h0);

        // Snooze interval, then stop beating snooze.
        retrigger();
        idle(3);
        tick(0, 0, 0, 0, 1, 0);
        chk("snooze_enter", 32'(ringing), 32'h0);
        n = 1;
        for (int i = 0; i < 100 && !ringing; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            if (!ringing) n++;
        end
        chk("snooze_len_cycles", 32'(n), 32'(SS * CF));
        chk("snooze_rering", 32'(ringing), 32'h1);
        tick(0, 0, 0, 1, 1, 0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            if (ringing) n++;
        end
        chk("stop_beats_snooze", 32'(n), 32'h0);

        // Disabling the alarm mid-ring drops to idle one edge later.
        retrigger();
        idle(2);
        tick(0, 0, 1, 0, 0, 1);
        chk("disarm_en", 32'(alarm_en), 32'h0);
        chk("disarm_lag", 32'(ringing), 32'h1);
        tick(0, 0, 0, 0, 0, 0);
        chk("disarm_idle", 32'(ringing), 32'h0);

        // Asynchronous reset while the buzzer is sounding.
        tick(0, 0, 1, 0, 0, 1);
        retrigger();
        for (int i = 0; i < 60 && !beep; i++) tick(0, 0, 0, 0, 0, 0);
        chk("beep_before_reset", 32'(beep), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_beep", 32'(beep), 32'h0);
        chk("async_ringing", 32'(ringing), 32'h0);
        chk("async_data_alarm", data_alarm, 32'h07a00a00);
        model_reset();
        #2 rst_n = 1'b1;

        // Randomized traffic.
        beep_seen = 0;
        tick(0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            logic sh, sm, ao, st, sn, md;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1: cur_cnt = {bcd(m_h), 4'ha, bcd(m_m), 4'ha, 8'h00};
                    2:    cur_cnt = {bcd(m_h), 4'ha, bcd(m_m), 4'ha,
                                     bcd(int'($urandom_range(1, 59)))};
                    default: cur_cnt = {bcd(int'($urandom_range(0, 23))), 4'ha,
                                        bcd(int'($urandom_range(0, 59))), 4'ha,
                                        bcd(int'($urandom_range(0, 59)))};
                endcase
            end
            md = ($urandom_range(0, 9) == 0);
            sh = ($urandom_range(0, 9) == 0);
            sm = ($urandom_range(0, 9) == 0);
            ao = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 59) == 0);
            sn = ($urandom_range(0, 39) == 0);
            tick(sh, sm, ao, st, sn, md);
        end
        chk("beep_active_random", 32'(beep_seen > 0), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
